// File: rtl/conv_pkg.sv
// Shared types and width helpers for the CNN tile sequencer.
// Width formulas live here so the top and the bench size ports identically.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CONV = 2'd2
   } state_e;

   // clog2 clamped to 1 so single-entry ranges still get a real bit
   function automatic int width_of(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int taps_of(input int tile_dim);
      return tile_dim * tile_dim;
   endfunction

   function automatic int tiles_of(input int img_dim, input int tile_dim);
      return (img_dim / tile_dim) * (img_dim / tile_dim);
   endfunction

endpackage

// File: rtl/conv_tile_sequencer_tile_tap_counter.sv
// Nested row/col walker with a running linear offset; advances on en_i, clr_i wins.
// row/col step by IDX_STEP, offset steps by STEP_COL per column and STEP_ROW per row.
module tile_tap_counter #(
   parameter int DIM      = 3,
   parameter int STEP_ROW = 12,
   parameter int STEP_COL = 1,
   parameter int IDX_STEP = 1,
   parameter int W        = 4,
   parameter int OW       = 10
) (
   input  logic          clk_i,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [W-1:0]  row_o,
   output logic [W-1:0]  col_o,
   output logic [OW-1:0] offset_o,
   output logic          last_o
);

   localparam int ROW_INC  = STEP_ROW - (DIM - 1) * STEP_COL;
   localparam int LAST_IDX = (DIM - 1) * IDX_STEP;

   logic [W-1:0]  row_q, row_d;
   logic [W-1:0]  col_q, col_d;
   logic [OW-1:0] off_q, off_d;
   logic          row_last, col_last;

   assign row_last = (row_q == W'(LAST_IDX));
   assign col_last = (col_q == W'(LAST_IDX));

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      off_d = off_q;
      if (clr_i) begin
         row_d = '0;
         col_d = '0;
         off_d = '0;
      end else if (en_i) begin
         if (col_last) begin
            col_d = '0;
            if (row_last) begin
               row_d = '0;
               off_d = '0;
            end else begin
               // jump from the end of one row to the start of the next
               row_d = row_q + W'(IDX_STEP);
               off_d = off_q + OW'(ROW_INC);
            end
         end else begin
            col_d = col_q + W'(IDX_STEP);
            off_d = off_q + OW'(STEP_COL);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      row_q <= row_d;
      col_q <= col_d;
      off_q <= off_d;
   end

   assign row_o    = row_q;
   assign col_o    = col_q;
   assign offset_o = off_q;
   assign last_o   = row_last & col_last;

endmodule

// File: rtl/conv_tile_sequencer.sv
// Per layer: stream filter taps, then walk every tile tap by tap; stall freezes everything.
// Addresses decode combinationally from state; dom_ready/dom_address lag the last-tap read by one cycle.
module conv_tile_sequencer
   import conv_pkg::*;
#(
   parameter int IMG_DIM     = 12,
   parameter int TILE_DIM    = 3,
   parameter int NUM_LAYERS  = 4,
   parameter int ADDR_W      = 10,
   parameter int FILTER_BASE = 0,
   parameter int IMAGE_BASE  = 64,
   localparam int TAPS = taps_of(TILE_DIM),
   localparam int GRID = IMG_DIM / TILE_DIM,
   localparam int T    = tiles_of(IMG_DIM, TILE_DIM),
   localparam int IW   = width_of(IMG_DIM),
   localparam int LW   = width_of(NUM_LAYERS),
   localparam int SW   = width_of(TAPS),
   localparam int DW   = width_of(T)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic              stall,
   output logic              finish,
   output logic              busy,
   output logic [IW-1:0]     i,
   output logic [IW-1:0]     j,
   output logic [LW-1:0]     layer,
   output logic [SW-1:0]     step,
   output logic              wen,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] bvm_address,
   output logic [DW-1:0]     dom_address,
   output logic              dom_ready
);

   if ((IMG_DIM % TILE_DIM) != 0) begin : g_bad_dims
      $error("IMG_DIM must be a multiple of TILE_DIM");
   end

   state_e            state_q, state_d;
   logic [LW-1:0]     layer_q, layer_d;
   logic [SW-1:0]     step_q, step_d;
   logic [ADDR_W-1:0] filt_q, filt_d;
   logic [DW-1:0]     tile_idx_q, tile_idx_d;
   logic              dom_ready_q;
   logic [DW-1:0]     dom_address_q;

   logic              start, adv, tile_done, clr;
   logic [IW-1:0]     tap_row, tap_col, tile_row, tile_col;
   logic [ADDR_W-1:0] tap_off, tile_off;
   logic              tap_last, tile_last;

   assign start     = (state_q == ST_IDLE) & go;
   assign adv       = (state_q != ST_IDLE) & ~stall;
   assign tile_done = adv & (state_q == ST_CONV) & tap_last;
   assign clr       = reset | start;

   tile_tap_counter #(
      .DIM(TILE_DIM), .STEP_ROW(IMG_DIM), .STEP_COL(1), .IDX_STEP(1),
      .W(IW), .OW(ADDR_W)
   ) u_tap (
      .clk_i(clock), .clr_i(clr), .en_i(adv),
      .row_o(tap_row), .col_o(tap_col), .offset_o(tap_off), .last_o(tap_last)
   );

   tile_tap_counter #(
      .DIM(GRID), .STEP_ROW(TILE_DIM * IMG_DIM), .STEP_COL(TILE_DIM), .IDX_STEP(TILE_DIM),
      .W(IW), .OW(ADDR_W)
   ) u_tile (
      .clk_i(clock), .clr_i(clr), .en_i(tile_done),
      .row_o(tile_row), .col_o(tile_col), .offset_o(tile_off), .last_o(tile_last)
   );

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d = ST_LOAD;
               layer_d = '0;
            end
         end
         ST_LOAD: begin
            if (adv && tap_last) state_d = ST_CONV;
         end
         ST_CONV: begin
            if (tile_done && tile_last) begin
               if (layer_q == LW'(NUM_LAYERS - 1)) begin
                  state_d = ST_IDLE;
                  layer_d = '0;
               end else begin
                  state_d = ST_LOAD;
                  layer_d = layer_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      step_d     = step_q;
      filt_d     = filt_q;
      tile_idx_d = tile_idx_q;
      if (start) begin
         step_d     = '0;
         filt_d     = '0;
         tile_idx_d = '0;
      end else begin
         if (adv) step_d = tap_last ? '0 : step_q + 1'b1;
         // filter pointer runs across layers, so it equals layer*TAPS + step
         if (adv && (state_q == ST_LOAD)) filt_d = filt_q + 1'b1;
         if (tile_done) tile_idx_d = tile_last ? '0 : tile_idx_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         layer_q       <= '0;
         step_q        <= '0;
         filt_q        <= '0;
         tile_idx_q    <= '0;
         dom_ready_q   <= 1'b0;
         dom_address_q <= '0;
      end else begin
         state_q     <= state_d;
         layer_q     <= layer_d;
         step_q      <= step_d;
         filt_q      <= filt_d;
         tile_idx_q  <= tile_idx_d;
         dom_ready_q <= tile_done;
         if (tile_done) dom_address_q <= tile_idx_q;
      end
   end

   always_comb begin
      i           = '0;
      j           = '0;
      bvm_address = '0;
      if (state_q == ST_LOAD) begin
         bvm_address = ADDR_W'(FILTER_BASE) + filt_q;
      end else if (state_q == ST_CONV) begin
         i           = tile_row + tap_row;
         j           = tile_col + tap_col;
         bvm_address = ADDR_W'(IMAGE_BASE) + tile_off + tap_off;
      end
   end

   assign finish      = (state_q == ST_IDLE);
   assign busy        = ~finish;
   assign wen         = (state_q == ST_LOAD);
   assign rd_valid    = adv;
   assign layer       = layer_q;
   assign step        = step_q;
   assign dom_ready   = dom_ready_q;
   assign dom_address = dom_address_q;

endmodule
